// File: rtl/axi_svt_reg_slice.sv
// AXI register slice: AW, W, B, AR and R each pass through an independent
// channel stage configured as bypass (0), full 2-entry skid (1) or forward (2).
// Optional macro AXI_SVT_REG_SLICE_WID_EN adds wid_m/wid_s to the W channel.

module axi_svt_reg_slice_chan #(
  parameter int unsigned Width = 8,
  parameter int unsigned Mode  = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             valid_in,
  input  logic [Width-1:0] payload_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [Width-1:0] payload_out,
  input  logic             ready_in
);

  if (Mode == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = aclk ^ aresetn;
    assign valid_out      = valid_in;
    assign payload_out    = payload_in;
    assign ready_out      = ready_in;
  end else if (Mode == 2) begin : g_fwd
    logic             valid_q;
    logic [Width-1:0] data_q;

    assign ready_out   = !valid_q | ready_in;
    assign valid_out   = valid_q;
    assign payload_out = data_q;

    // Single stage: reload whenever the held beat leaves or the stage is empty
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (ready_out) begin
        valid_q <= valid_in;
        if (valid_in) data_q <= payload_in;
      end
    end
  end else begin : g_full
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] main_q, main_d, skid_q, skid_d;
    logic             ready_q;
    logic             accept, drain;

    assign accept      = valid_in & ready_q;
    assign drain       = (state_q != StEmpty) & ready_in;
    assign valid_out   = (state_q != StEmpty);
    assign payload_out = main_q;
    assign ready_out   = ready_q;

    // Next-state: skid only fills when a beat arrives while main is stuck
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = payload_in;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_d = payload_in;
          end else if (accept) begin
            skid_d  = payload_in;
            state_d = StTwo;
          end else if (drain) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    // State and payload registers; ready is registered so ready_in never reaches ready_out
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state_q <= StEmpty;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != StTwo);
      end
    end
  end

endmodule

module axi_svt_reg_slice #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned AW_MODE    = 1,
  parameter int unsigned AR_MODE    = 1,
  parameter int unsigned W_MODE     = 1,
  parameter int unsigned R_MODE     = 1,
  parameter int unsigned B_MODE     = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // AW
  input  logic                    awvalid_m,
  input  logic [ADDR_WIDTH-1:0]   awaddr_m,
  input  logic [LEN_WIDTH-1:0]    awlen_m,
  input  logic [2:0]              awsize_m,
  input  logic [1:0]              awburst_m,
  input  logic [1:0]              awlock_m,
  input  logic [3:0]              awcache_m,
  input  logic [2:0]              awprot_m,
  input  logic [ID_WIDTH-1:0]     awid_m,
  output logic                    awready_m,
  output logic                    awvalid_s,
  output logic [ADDR_WIDTH-1:0]   awaddr_s,
  output logic [LEN_WIDTH-1:0]    awlen_s,
  output logic [2:0]              awsize_s,
  output logic [1:0]              awburst_s,
  output logic [1:0]              awlock_s,
  output logic [3:0]              awcache_s,
  output logic [2:0]              awprot_s,
  output logic [ID_WIDTH-1:0]     awid_s,
  input  logic                    awready_s,
  // AR
  input  logic                    arvalid_m,
  input  logic [ADDR_WIDTH-1:0]   araddr_m,
  input  logic [LEN_WIDTH-1:0]    arlen_m,
  input  logic [2:0]              arsize_m,
  input  logic [1:0]              arburst_m,
  input  logic [1:0]              arlock_m,
  input  logic [3:0]              arcache_m,
  input  logic [2:0]              arprot_m,
  input  logic [ID_WIDTH-1:0]     arid_m,
  output logic                    arready_m,
  output logic                    arvalid_s,
  output logic [ADDR_WIDTH-1:0]   araddr_s,
  output logic [LEN_WIDTH-1:0]    arlen_s,
  output logic [2:0]              arsize_s,
  output logic [1:0]              arburst_s,
  output logic [1:0]              arlock_s,
  output logic [3:0]              arcache_s,
  output logic [2:0]              arprot_s,
  output logic [ID_WIDTH-1:0]     arid_s,
  input  logic                    arready_s,
  // W
  input  logic                    wvalid_m,
  input  logic                    wlast_m,
  input  logic [DATA_WIDTH-1:0]   wdata_m,
  input  logic [DATA_WIDTH/8-1:0] wstrb_m,
`ifdef AXI_SVT_REG_SLICE_WID_EN
  input  logic [ID_WIDTH-1:0]     wid_m,
  output logic [ID_WIDTH-1:0]     wid_s,
`endif
  output logic                    wready_m,
  output logic                    wvalid_s,
  output logic                    wlast_s,
  output logic [DATA_WIDTH-1:0]   wdata_s,
  output logic [DATA_WIDTH/8-1:0] wstrb_s,
  input  logic                    wready_s,
  // R
  input  logic                    rvalid_s,
  input  logic                    rlast_s,
  input  logic [DATA_WIDTH-1:0]   rdata_s,
  input  logic [1:0]              rresp_s,
  input  logic [ID_WIDTH-1:0]     rid_s,
  output logic                    rready_s,
  output logic                    rvalid_m,
  output logic                    rlast_m,
  output logic [DATA_WIDTH-1:0]   rdata_m,
  output logic [1:0]              rresp_m,
  output logic [ID_WIDTH-1:0]     rid_m,
  input  logic                    rready_m,
  // B
  input  logic                    bvalid_s,
  input  logic [1:0]              bresp_s,
  input  logic [ID_WIDTH-1:0]     bid_s,
  output logic                    bready_s,
  output logic                    bvalid_m,
  output logic [1:0]              bresp_m,
  output logic [ID_WIDTH-1:0]     bid_m,
  input  logic                    bready_m
);

  localparam int unsigned AxWidth = ADDR_WIDTH + LEN_WIDTH + 3 + 2 + 2 + 4 + 3 + ID_WIDTH;
`ifdef AXI_SVT_REG_SLICE_WID_EN
  localparam int unsigned WWidth  = ID_WIDTH + 1 + DATA_WIDTH + DATA_WIDTH / 8;
`else
  localparam int unsigned WWidth  = 1 + DATA_WIDTH + DATA_WIDTH / 8;
`endif
  localparam int unsigned RWidth  = 1 + DATA_WIDTH + 2 + ID_WIDTH;
  localparam int unsigned BWidth  = 2 + ID_WIDTH;

  logic [AxWidth-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [WWidth-1:0]  w_in, w_out;
  logic [RWidth-1:0]  r_in, r_out;
  logic [BWidth-1:0]  b_in, b_out;

  assign aw_in = {awaddr_m, awlen_m, awsize_m, awburst_m, awlock_m, awcache_m, awprot_m, awid_m};
  assign {awaddr_s, awlen_s, awsize_s, awburst_s, awlock_s, awcache_s, awprot_s, awid_s} = aw_out;
  assign ar_in = {araddr_m, arlen_m, arsize_m, arburst_m, arlock_m, arcache_m, arprot_m, arid_m};
  assign {araddr_s, arlen_s, arsize_s, arburst_s, arlock_s, arcache_s, arprot_s, arid_s} = ar_out;
`ifdef AXI_SVT_REG_SLICE_WID_EN
  assign w_in = {wid_m, wlast_m, wdata_m, wstrb_m};
  assign {wid_s, wlast_s, wdata_s, wstrb_s} = w_out;
`else
  assign w_in = {wlast_m, wdata_m, wstrb_m};
  assign {wlast_s, wdata_s, wstrb_s} = w_out;
`endif
  assign r_in = {rlast_s, rdata_s, rresp_s, rid_s};
  assign {rlast_m, rdata_m, rresp_m, rid_m} = r_out;
  assign b_in = {bresp_s, bid_s};
  assign {bresp_m, bid_m} = b_out;

  axi_svt_reg_slice_chan #(.Width(AxWidth), .Mode(AW_MODE)) u_aw (
    .aclk(aclk), .aresetn(aresetn),
    .valid_in(awvalid_m), .payload_in(aw_in), .ready_out(awready_m),
    .valid_out(awvalid_s), .payload_out(aw_out), .ready_in(awready_s)
  );

  axi_svt_reg_slice_chan #(.Width(AxWidth), .Mode(AR_MODE)) u_ar (
    .aclk(aclk), .aresetn(aresetn),
    .valid_in(arvalid_m), .payload_in(ar_in), .ready_out(arready_m),
    .valid_out(arvalid_s), .payload_out(ar_out), .ready_in(arready_s)
  );

  axi_svt_reg_slice_chan #(.Width(WWidth), .Mode(W_MODE)) u_w (
    .aclk(aclk), .aresetn(aresetn),
    .valid_in(wvalid_m), .payload_in(w_in), .ready_out(wready_m),
    .valid_out(wvalid_s), .payload_out(w_out), .ready_in(wready_s)
  );

  axi_svt_reg_slice_chan #(.Width(RWidth), .Mode(R_MODE)) u_r (
    .aclk(aclk), .aresetn(aresetn),
    .valid_in(rvalid_s), .payload_in(r_in), .ready_out(rready_s),
    .valid_out(rvalid_m), .payload_out(r_out), .ready_in(rready_m)
  );

  axi_svt_reg_slice_chan #(.Width(BWidth), .Mode(B_MODE)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .valid_in(bvalid_s), .payload_in(b_in), .ready_out(bready_s),
    .valid_out(bvalid_m), .payload_out(b_out), .ready_in(bready_m)
  );

endmodule

// File: tb/tb_axi_svt_reg_slice.sv
// Directed bench: u_full uses default modes (all full skid); u_mix uses bypass on
// AW/AR/B and forward on W/R. Both share master/slave stimulus except the R source.
module tb_axi_svt_reg_slice;
  logic aclk, aresetn;
  int checks = 0, failures = 0;

  // Shared stimulus
  logic awvalid_m, awready_s, arvalid_m, arready_s, wvalid_m, wlast_m, wready_s;
  logic [31:0] awaddr_m, araddr_m;
  logic [7:0]  awlen_m, arlen_m, wstrb_m;
  logic [2:0]  awsize_m, arsize_m, awprot_m, arprot_m;
  logic [1:0]  awburst_m, arburst_m, awlock_m, arlock_m, bresp_s, rresp_s, p_rresp_s;
  logic [3:0]  awcache_m, arcache_m, awid_m, arid_m, bid_s, rid_s, p_rid_s;
  logic [63:0] wdata_m, rdata_s, p_rdata_s;
  logic rvalid_s, rlast_s, p_rvalid_s, p_rlast_s, rready_m, bvalid_s, bready_m;
`ifdef AXI_SVT_REG_SLICE_WID_EN
  logic [3:0] wid_m, f_wid_s, p_wid_s;
`endif

  // Observed outputs, f_ = u_full, p_ = u_mix
  logic f_awready_m, f_awvalid_s, f_arready_m, f_arvalid_s, f_wready_m, f_wvalid_s, f_wlast_s;
  logic p_awready_m, p_awvalid_s, p_arready_m, p_arvalid_s, p_wready_m, p_wvalid_s, p_wlast_s;
  logic [31:0] f_awaddr_s, f_araddr_s, p_awaddr_s, p_araddr_s;
  logic [7:0]  f_awlen_s, f_arlen_s, p_awlen_s, p_arlen_s, f_wstrb_s, p_wstrb_s;
  logic [2:0]  f_awsize_s, f_arsize_s, p_awsize_s, p_arsize_s;
  logic [2:0]  f_awprot_s, f_arprot_s, p_awprot_s, p_arprot_s;
  logic [1:0]  f_awburst_s, f_arburst_s, p_awburst_s, p_arburst_s;
  logic [1:0]  f_awlock_s, f_arlock_s, p_awlock_s, p_arlock_s;
  logic [3:0]  f_awcache_s, f_arcache_s, p_awcache_s, p_arcache_s;
  logic [3:0]  f_awid_s, f_arid_s, p_awid_s, p_arid_s, f_rid_m, p_rid_m, f_bid_m, p_bid_m;
  logic [63:0] f_wdata_s, p_wdata_s, f_rdata_m, p_rdata_m;
  logic f_rready_s, f_rvalid_m, f_rlast_m, p_rready_s, p_rvalid_m, p_rlast_m;
  logic [1:0] f_rresp_m, p_rresp_m, f_bresp_m, p_bresp_m;
  logic f_bready_s, f_bvalid_m, p_bready_s, p_bvalid_m;

  axi_svt_reg_slice u_full (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid_m(awvalid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
    .awburst_m(awburst_m), .awlock_m(awlock_m), .awcache_m(awcache_m), .awprot_m(awprot_m),
    .awid_m(awid_m), .awready_m(f_awready_m),
    .awvalid_s(f_awvalid_s), .awaddr_s(f_awaddr_s), .awlen_s(f_awlen_s), .awsize_s(f_awsize_s),
    .awburst_s(f_awburst_s), .awlock_s(f_awlock_s), .awcache_s(f_awcache_s),
    .awprot_s(f_awprot_s), .awid_s(f_awid_s), .awready_s(awready_s),
    .arvalid_m(arvalid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arburst_m(arburst_m), .arlock_m(arlock_m), .arcache_m(arcache_m), .arprot_m(arprot_m),
    .arid_m(arid_m), .arready_m(f_arready_m),
    .arvalid_s(f_arvalid_s), .araddr_s(f_araddr_s), .arlen_s(f_arlen_s), .arsize_s(f_arsize_s),
    .arburst_s(f_arburst_s), .arlock_s(f_arlock_s), .arcache_s(f_arcache_s),
    .arprot_s(f_arprot_s), .arid_s(f_arid_s), .arready_s(arready_s),
    .wvalid_m(wvalid_m), .wlast_m(wlast_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m),
`ifdef AXI_SVT_REG_SLICE_WID_EN
    .wid_m(wid_m), .wid_s(f_wid_s),
`endif
    .wready_m(f_wready_m), .wvalid_s(f_wvalid_s), .wlast_s(f_wlast_s), .wdata_s(f_wdata_s),
    .wstrb_s(f_wstrb_s), .wready_s(wready_s),
    .rvalid_s(rvalid_s), .rlast_s(rlast_s), .rdata_s(rdata_s), .rresp_s(rresp_s),
    .rid_s(rid_s), .rready_s(f_rready_s), .rvalid_m(f_rvalid_m), .rlast_m(f_rlast_m),
    .rdata_m(f_rdata_m), .rresp_m(f_rresp_m), .rid_m(f_rid_m), .rready_m(rready_m),
    .bvalid_s(bvalid_s), .bresp_s(bresp_s), .bid_s(bid_s), .bready_s(f_bready_s),
    .bvalid_m(f_bvalid_m), .bresp_m(f_bresp_m), .bid_m(f_bid_m), .bready_m(bready_m)
  );

  axi_svt_reg_slice #(
    .AW_MODE(0), .AR_MODE(0), .B_MODE(0), .W_MODE(2), .R_MODE(2)
  ) u_mix (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid_m(awvalid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
    .awburst_m(awburst_m), .awlock_m(awlock_m), .awcache_m(awcache_m), .awprot_m(awprot_m),
    .awid_m(awid_m), .awready_m(p_awready_m),
    .awvalid_s(p_awvalid_s), .awaddr_s(p_awaddr_s), .awlen_s(p_awlen_s), .awsize_s(p_awsize_s),
    .awburst_s(p_awburst_s), .awlock_s(p_awlock_s), .awcache_s(p_awcache_s),
    .awprot_s(p_awprot_s), .awid_s(p_awid_s), .awready_s(awready_s),
    .arvalid_m(arvalid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arburst_m(arburst_m), .arlock_m(arlock_m), .arcache_m(arcache_m), .arprot_m(arprot_m),
    .arid_m(arid_m), .arready_m(p_arready_m),
    .arvalid_s(p_arvalid_s), .araddr_s(p_araddr_s), .arlen_s(p_arlen_s), .arsize_s(p_arsize_s),
    .arburst_s(p_arburst_s), .arlock_s(p_arlock_s), .arcache_s(p_arcache_s),
    .arprot_s(p_arprot_s), .arid_s(p_arid_s), .arready_s(arready_s),
    .wvalid_m(wvalid_m), .wlast_m(wlast_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m),
`ifdef AXI_SVT_REG_SLICE_WID_EN
    .wid_m(wid_m), .wid_s(p_wid_s),
`endif
    .wready_m(p_wready_m), .wvalid_s(p_wvalid_s), .wlast_s(p_wlast_s), .wdata_s(p_wdata_s),
    .wstrb_s(p_wstrb_s), .wready_s(wready_s),
    .rvalid_s(p_rvalid_s), .rlast_s(p_rlast_s), .rdata_s(p_rdata_s), .rresp_s(p_rresp_s),
    .rid_s(p_rid_s), .rready_s(p_rready_s), .rvalid_m(p_rvalid_m), .rlast_m(p_rlast_m),
    .rdata_m(p_rdata_m), .rresp_m(p_rresp_m), .rid_m(p_rid_m), .rready_m(rready_m),
    .bvalid_s(bvalid_s), .bresp_s(bresp_s), .bid_s(bid_s), .bready_s(p_bready_s),
    .bvalid_m(p_bvalid_m), .bresp_m(p_bresp_m), .bid_m(p_bid_m), .bready_m(bready_m)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    int fi, fo, pi, po;
    logic e_rdy, e_vld, f_acc, f_del, p_acc, p_del, saw_stall;
    logic [63:0] e_data;

    aresetn = 1'b0;
    {awvalid_m, awready_s, arvalid_m, arready_s, wvalid_m, wlast_m, wready_s} = '0;
    {rvalid_s, rlast_s, p_rvalid_s, p_rlast_s, rready_m, bvalid_s, bready_m} = '0;
    awaddr_m = '0; araddr_m = '0; awlen_m = '0; arlen_m = '0; wstrb_m = '0;
    awsize_m = 3'd3; arsize_m = 3'd3; awprot_m = '0; arprot_m = '0;
    awburst_m = 2'b01; arburst_m = 2'b01; awlock_m = '0; arlock_m = '0;
    awcache_m = 4'h3; arcache_m = 4'h3; awid_m = '0; arid_m = '0;
    bresp_s = '0; rresp_s = '0; p_rresp_s = '0; bid_s = '0; rid_s = '0; p_rid_s = '0;
    wdata_m = '0; rdata_s = '0; p_rdata_s = '0;
`ifdef AXI_SVT_REG_SLICE_WID_EN
    wid_m = 4'h5;
`endif

    // Reset state
    tick; tick;
    chk("rst_f_awvalid", f_awvalid_s, 1'b0);
    chk("rst_f_awready", f_awready_m, 1'b0);
    chk("rst_f_wready", f_wready_m, 1'b0);
    chk("rst_f_rready", f_rready_s, 1'b0);
    chk("rst_f_bvalid", f_bvalid_m, 1'b0);
    chk("rst_f_awaddr", f_awaddr_s, 32'h0);
    chk("rst_p_wready", p_wready_m, 1'b1);
    chk("rst_p_rready", p_rready_s, 1'b1);
    chk("rst_p_wvalid", p_wvalid_s, 1'b0);
    aresetn = 1'b1;
    #1;
    chk("rel_f_awready_pre", f_awready_m, 1'b0);
    tick;
    chk("rel_f_awready", f_awready_m, 1'b1);
    chk("rel_f_wready", f_wready_m, 1'b1);

    // 16-beat write, wready_s held high
    wready_s = 1'b1;
    wstrb_m  = 8'hFF;
    for (int k = 0; k <= 16; k++) begin
      wvalid_m = (k < 16);
      wdata_m  = 64'h1000 + 64'(k);
      wlast_m  = (k == 15);
      #1;
      chk("w_f_ready", f_wready_m, 1'b1);
      chk("w_p_ready", p_wready_m, 1'b1);
      e_vld  = (k >= 1);
      checks++;
      if (f_wvalid_s !== e_vld) begin
        failures++;
        $error("FAIL w_f_valid observed=%0h expected=%0h", f_wvalid_s, e_vld);
      end
      checks++;
      if (p_wvalid_s !== e_vld) begin
        failures++;
        $error("FAIL w_p_valid observed=%0h expected=%0h", p_wvalid_s, e_vld);
      end
      if (k >= 1) begin
        e_data = 64'h1000 + 64'(k - 1);
        chk("w_f_data", f_wdata_s, e_data);
        chk("w_p_data", p_wdata_s, e_data);
        chk("w_f_last", f_wlast_s, (k == 16));
        chk("w_p_last", p_wlast_s, (k == 16));
        chk("w_f_strb", f_wstrb_s, 8'hFF);
`ifdef AXI_SVT_REG_SLICE_WID_EN
        chk("w_f_wid", f_wid_s, 4'h5);
        chk("w_p_wid", p_wid_s, 4'h5);
`endif
      end
      tick;
    end
    wvalid_m = 1'b0;
    wlast_m  = 1'b0;
    #1;
    chk("w_f_drained", f_wvalid_s, 1'b0);

    // B response: full returns it 1 cycle later, bypass immediately
    bready_m = 1'b1; bvalid_s = 1'b1; bresp_s = 2'b00; bid_s = 4'h5;
    #1;
    chk("b_f_lat0", f_bvalid_m, 1'b0);
    chk("b_p_valid", p_bvalid_m, 1'b1);
    chk("b_p_bid", p_bid_m, 4'h5);
    chk("b_p_ready", p_bready_s, 1'b1);
    tick;
    bvalid_s = 1'b0; bid_s = 4'h0;
    #1;
    chk("b_f_valid", f_bvalid_m, 1'b1);
    chk("b_f_resp", f_bresp_m, 2'b00);
    chk("b_f_bid", f_bid_m, 4'h5);
    tick;
    chk("b_f_done", f_bvalid_m, 1'b0);

    // AR: araddr 0x1000 id 3, bypass zero latency vs full one cycle
    arvalid_m = 1'b1; araddr_m = 32'h1000; arid_m = 4'h3; arready_s = 1'b0;
    #1;
    chk("ar_p_valid", p_arvalid_s, 1'b1);
    chk("ar_p_addr", p_araddr_s, 32'h1000);
    chk("ar_p_id", p_arid_s, 4'h3);
    chk("ar_p_ready0", p_arready_m, 1'b0);
    chk("ar_f_lat0", f_arvalid_s, 1'b0);
    arready_s = 1'b1;
    #1;
    chk("ar_p_ready1", p_arready_m, 1'b1);
    tick;
    arvalid_m = 1'b0; araddr_m = '0; arid_m = '0;
    #1;
    chk("ar_f_valid", f_arvalid_s, 1'b1);
    chk("ar_f_addr", f_araddr_s, 32'h1000);
    chk("ar_f_id", f_arid_s, 4'h3);
    chk("ar_p_idle", p_arvalid_s, 1'b0);
    tick;
    chk("ar_f_done", f_arvalid_s, 1'b0);

    // AW skid: slave stalls, three addresses offered
    awready_s = 1'b0; awvalid_m = 1'b1; awaddr_m = 32'hA0; awlen_m = 8'd15; awid_m = 4'h2;
    #1;
    chk("aw_f_rdy_a", f_awready_m, 1'b1);
    chk("aw_f_vld_a", f_awvalid_s, 1'b0);
    chk("aw_p_addr", p_awaddr_s, 32'hA0);
    chk("aw_p_ready", p_awready_m, 1'b0);
    tick;
    awaddr_m = 32'hA1;
    #1;
    chk("aw_f_rdy_b", f_awready_m, 1'b1);
    chk("aw_f_addr_b", f_awaddr_s, 32'hA0);
    tick;
    awaddr_m = 32'hA2;
    #1;
    chk("aw_f_rdy_c", f_awready_m, 1'b0);
    chk("aw_f_addr_c", f_awaddr_s, 32'hA0);
    chk("aw_f_len_c", f_awlen_s, 8'd15);
    chk("aw_f_id_c", f_awid_s, 4'h2);
    tick;
    awready_s = 1'b1;
    #1;
    chk("aw_f_rdy_d", f_awready_m, 1'b0);
    chk("aw_f_addr_d", f_awaddr_s, 32'hA0);
    chk("aw_p_ready_d", p_awready_m, 1'b1);
    tick;
    chk("aw_f_addr_e", f_awaddr_s, 32'hA1);
    chk("aw_f_rdy_e", f_awready_m, 1'b1);
    tick;
    awvalid_m = 1'b0;
    #1;
    chk("aw_f_vld_f", f_awvalid_s, 1'b1);
    chk("aw_f_addr_f", f_awaddr_s, 32'hA2);
    tick;
    chk("aw_f_vld_g", f_awvalid_s, 1'b0);

    // 8-beat read, rready_m low for cycles 3..5; occupancy model per instance
    fi = 0; fo = 0; pi = 0; po = 0; saw_stall = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rready_m   = !(c >= 3 && c <= 5);
      rvalid_s   = (fi < 8);
      rdata_s    = 64'hA0 + 64'(fi);
      rlast_s    = (fi == 7);
      rid_s      = 4'h3;
      p_rvalid_s = (pi < 8);
      p_rdata_s  = 64'hB0 + 64'(pi);
      p_rlast_s  = (pi == 7);
      p_rid_s    = 4'h6;
      #1;
      e_rdy = ((fi - fo) < 2);
      e_vld = ((fi - fo) > 0);
      checks++;
      if (f_rready_s !== e_rdy) begin
        failures++;
        $error("FAIL r_f_ready observed=%0h expected=%0h", f_rready_s, e_rdy);
      end
      chk("r_f_valid", f_rvalid_m, e_vld);
      if (e_vld) begin
        e_data = 64'hA0 + 64'(fo);
        chk("r_f_data", f_rdata_m, e_data);
        chk("r_f_last", f_rlast_m, (fo == 7));
        chk("r_f_id", f_rid_m, 4'h3);
      end
      f_acc = rvalid_s && e_rdy;
      f_del = e_vld && rready_m;
      e_rdy = rready_m | (pi == po);
      e_vld = (pi != po);
      checks++;
      if (p_rready_s !== e_rdy) begin
        failures++;
        $error("FAIL r_p_ready observed=%0h expected=%0h", p_rready_s, e_rdy);
      end
      chk("r_p_valid", p_rvalid_m, e_vld);
      if (e_vld) begin
        e_data = 64'hB0 + 64'(po);
        chk("r_p_data", p_rdata_m, e_data);
        chk("r_p_last", p_rlast_m, (po == 7));
        chk("r_p_id", p_rid_m, 4'h6);
      end
      p_acc = p_rvalid_s && e_rdy;
      p_del = e_vld && rready_m;
      tick;
      fi += int'(f_acc); fo += int'(f_del);
      pi += int'(p_acc); po += int'(p_del);
      if ((fi - fo) == 2) saw_stall = 1'b1;
    end
    rvalid_s = 1'b0; p_rvalid_s = 1'b0;
    chk("r_f_count", fo, 8);
    chk("r_p_count", po, 8);
    chk("r_f_stalled", saw_stall, 1'b1);

    // Reset with two W beats buffered in full, one in forward
    wready_s = 1'b0; wvalid_m = 1'b1; wdata_m = 64'hD0;
    tick;
    wdata_m = 64'hD1;
    tick;
    wvalid_m = 1'b0;
    #1;
    chk("wr_f_ready_full", f_wready_m, 1'b0);
    chk("wr_f_data_held", f_wdata_s, 64'hD0);
    chk("wr_p_data_held", p_wdata_s, 64'hD0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("wr_f_valid_rst", f_wvalid_s, 1'b0);
    chk("wr_f_data_rst", f_wdata_s, 64'h0);
    chk("wr_f_ready_rst", f_wready_m, 1'b0);
    chk("wr_p_valid_rst", p_wvalid_s, 1'b0);
    chk("wr_p_ready_rst", p_wready_m, 1'b1);
    tick;
    aresetn = 1'b1; wready_s = 1'b1;
    #1;
    chk("wr_f_ready_pre", f_wready_m, 1'b0);
    chk("wr_f_valid_pre", f_wvalid_s, 1'b0);
    tick;
    chk("wr_f_ready_post", f_wready_m, 1'b1);
    chk("wr_f_valid_post", f_wvalid_s, 1'b0);
    chk("wr_p_valid_post", p_wvalid_s, 1'b0);
    tick;
    chk("wr_f_valid_post2", f_wvalid_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
